// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and width helper for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick of the first set request at or above ptr, wrapping to 0
module rr_pick import uart_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [clog2w(NREQ)-1:0] ptr,
  output logic [clog2w(NREQ)-1:0] grant,
  output logic                    valid
);
  localparam int W = clog2w(NREQ);
  // Lowest set bit overall is the wrap fallback; a set bit at or above ptr overrides it.
  always_comb begin
    grant = '0;
    valid = |req;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) grant = W'(i);
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i] && W'(i) >= ptr) grant = W'(i);
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding one uart_tx from NREQ requesters, with a watchdog
module uart_tx_arb import uart_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DBIT-1:0]    din,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_din,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic [clog2w(NREQ)-1:0] owner,
  output logic                    timeout_err
);
  localparam int W  = clog2w(NREQ);
  localparam int WW = clog2w(TIMEOUT);
  state_t state, state_nxt;
  logic [W-1:0] grant, rr_ptr;
  logic [WW-1:0] wdog;
  logic valid, pick, done, tmo;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(rr_ptr), .grant(grant), .valid(valid));
  // Timeout fires on the edge where the counter would reach TIMEOUT-1; a done tick wins.
  always_comb begin
    pick      = state == IDLE && valid;
    done      = state == WAIT && tx_done_tick;
    tmo       = state == WAIT && !tx_done_tick && wdog + 1'b1 == WW'(TIMEOUT - 1);
    state_nxt = (state == IDLE) ? (valid ? START : IDLE) :
                (state == START) ? WAIT :
                (state == WAIT && !(done || tmo)) ? WAIT : IDLE;
  end
  // Outputs are registered from the next-state decision so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      ack         <= '0;
      tx_din      <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
    end else begin
      state       <= state_nxt;
      tx_start    <= pick;
      ack         <= pick ? NREQ'(1) << grant : '0;
      busy        <= state_nxt != IDLE;
      timeout_err <= tmo;
      wdog        <= (state == WAIT) ? wdog + 1'b1 : '0;
      if (pick) begin
        tx_din <= din[grant*DBIT +: DBIT];
        owner  <= grant;
      end
      if (done || tmo) rr_ptr <= (owner == W'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed checks of arbitration, latency, fairness, watchdog and reset
module tb_uart_tx_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done_tick;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_err;
  int total = 0;
  int bad = 0;
  int n;
  uart_tx_arb #(.NREQ(4), .DBIT(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .ack(ack), .tx_start(tx_start),
    .tx_din(tx_din), .tx_done_tick(tx_done_tick), .busy(busy), .owner(owner),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic done_pulse();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench timeout");
  end
  initial begin
    reset = 1'b1; req = '0; din = '0; tx_done_tick = 1'b0;
    step(); step();
    chk("rst_ack", ack, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_txdin", tx_din, 0);
    chk("rst_tmo", timeout_err, 0);
    reset = 1'b0;
    step();
    din = 32'h00A5_0000;
    req = 4'b0100;
    step();
    chk("single_start", tx_start, 1);
    chk("single_ack", ack, 4'b0100);
    chk("single_byte", tx_din, 8'hA5);
    chk("single_owner", owner, 2);
    chk("single_busy", busy, 1);
    req = '0;
    din = 32'h00FF_0000;
    step();
    chk("single_start_off", tx_start, 0);
    chk("single_ack_off", ack, 0);
    step(); step();
    chk("din_hold", tx_din, 8'hA5);
    chk("wait_busy", busy, 1);
    done_pulse();
    chk("done_idle", busy, 0);
    chk("done_no_tmo", timeout_err, 0);
    din = 32'h4433_2211;
    req = 4'b1001;
    step();
    chk("wrap_first_ack", ack, 4'b1000);
    chk("wrap_first_byte", tx_din, 8'h44);
    req = 4'b0001;
    step();
    done_pulse();
    chk("b2b_gap", tx_start, 0);
    step();
    chk("wrap_second_ack", ack, 4'b0001);
    chk("wrap_second_byte", tx_din, 8'h11);
    chk("wrap_second_start", tx_start, 1);
    req = '0;
    step();
    done_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      n = 0;
      while (!tx_start && n < 8) begin
        step();
        n++;
      end
      chk("fair_start", tx_start, 1);
      chk("fair_ack", ack, 32'(1 << (f % 4)));
      chk("fair_byte", tx_din, 32'(8'h11 * (f % 4 + 1)));
      step();
      done_pulse();
    end
    req = '0;
    step();
    done_pulse();
    chk("stray_busy", busy, 0);
    chk("stray_ack", ack, 0);
    chk("stray_start", tx_start, 0);
    req = 4'b0100;
    step();
    chk("wd_start", tx_start, 1);
    chk("wd_ack", ack, 4'b0100);
    req = '0;
    n = 0;
    while (!timeout_err && n < 40) begin
      step();
      n++;
    end
    chk("wd_delay", n, 16);
    chk("wd_pulse", timeout_err, 1);
    chk("wd_idle", busy, 0);
    req = 4'b0010;
    step();
    chk("wd_next_ack", ack, 4'b0010);
    chk("wd_next_start", tx_start, 1);
    chk("wd_pulse_end", timeout_err, 0);
    req = '0;
    for (int i = 0; i < 15; i++) step();
    done_pulse();
    chk("tie_no_tmo", timeout_err, 0);
    chk("tie_idle", busy, 0);
    step();
    chk("tie_no_tmo_late", timeout_err, 0);
    req = 4'b1000;
    step();
    chk("mr_start", tx_start, 1);
    req = '0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_owner", owner, 0);
    chk("mr_txdin", tx_din, 0);
    chk("mr_ack", ack, 0);
    step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tx_start || ack != 0) n++;
    end
    chk("mr_no_spurious", n, 0);
    chk("mr_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Parameters
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 The block SHALL have parameter DBIT, default 8: data bits per frame, equal to the uart_tx DBIT.
REQ-003 The block SHALL have parameter TIMEOUT, default 4096: clk cycles to wait for tx_done_tick before abort.

Interface
REQ-004 The block SHALL have port clk, input, width 1: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, width NREQ: per-requester level request; held until ack.
REQ-007 The block SHALL have port din, input, width NREQ*DBIT: requester i data is bits [i*DBIT +: DBIT].
REQ-008 The block SHALL have port ack, output, width NREQ: one-hot, 1-cycle pulse; the winner's byte is accepted.
REQ-009 The block SHALL have port tx_start, output, width 1: 1-cycle pulse to uart_tx.
REQ-010 The block SHALL have port tx_din, output, width DBIT: registered byte to uart_tx; stable from tx_start until tx_done_tick.
REQ-011 The block SHALL have port tx_done_tick, input, width 1: frame-complete pulse from uart_tx.
REQ-012 The block SHALL have port busy, output, width 1: high in the START and WAIT states.
REQ-013 The block SHALL have port owner, output, width clog2(NREQ): index of the current or last winner.
REQ-014 The block SHALL have port timeout_err, output, width 1: 1-cycle pulse on watchdog abort.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, START and WAIT.
REQ-016 IDLE: if req != 0, the block SHALL select a winner on this edge, register din[winner] into tx_din, register owner, and go to START; otherwise it stays in IDLE.
REQ-017 Winner selection SHALL be round-robin: the first set req bit at or above rr_ptr, wrapping from NREQ-1 to 0.
REQ-018 START: the block SHALL assert tx_start and ack[owner] for exactly one cycle, clear the watchdog counter, and go to WAIT.
REQ-019 Latency: req sampled high at edge k SHALL give tx_start and ack high during cycle k+1.
REQ-020 WAIT: on tx_done_tick, the block SHALL set rr_ptr to (owner+1) mod NREQ and go to IDLE.
REQ-021 WAIT: the watchdog counter SHALL increment each cycle; on reaching TIMEOUT-1 without tx_done_tick, the block SHALL pulse timeout_err, advance rr_ptr as in REQ-020, and go to IDLE.
REQ-022 tx_done_tick and timeout in the same cycle: done SHALL win and timeout_err SHALL stay 0.
REQ-023 tx_done_tick in IDLE or START SHALL be ignored.
REQ-024 Back-to-back operation: the earliest next tx_start SHALL be 2 cycles after tx_done_tick (WAIT->IDLE, IDLE->START).
REQ-025 A requester deasserting req after selection SHALL not cancel the frame; the latched byte is still sent and acked.
REQ-026 A requester holding req after its ack SHALL be treated as a new request and is subject to round-robin fairness.
REQ-027 Changes on din after selection SHALL not affect tx_din.
REQ-028 With all NREQ requesters continuously active, every requester SHALL be served once per NREQ frames.

Reset
REQ-029 While reset is high, the block SHALL set state=IDLE, tx_start=0, ack=0, tx_din=0, owner=0, rr_ptr=0, busy=0, timeout_err=0 and watchdog=0, asynchronously.
REQ-030 Reset during START or WAIT SHALL abort the frame without an ack or tx_start pulse after reset release.
REQ-031 After reset deassertion, the first arbitration SHALL start from rr_ptr=0.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state encoding (IDLE=0, START=1, WAIT=2) and the clog2 width helper.
REQ-033 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs grant index and valid).
REQ-034 All outputs SHALL be registered; tx_din SHALL connect directly to uart_tx tx_din.

Verification
REQ-035 Single request: req=4'b0100 with din[2]=8'hA5 -> tx_start and ack=4'b0100 one cycle later, then serial link 0xA5 decoded by uart_rx with frame_error=0.
REQ-036 All four requesters with bytes 11,22,33,44 held continuously -> frames sent in order 11,22,33,44,11; one ack per frame.
REQ-037 Wrap-around: rr_ptr=3 and req=4'b1001 -> requester 3 served first, then requester 0.
REQ-038 Watchdog: TIMEOUT=16 and tx_done_tick tied to 0 -> timeout_err pulse 16 cycles after tx_start, FSM back in IDLE, next request then granted.
REQ-039 Mid-frame reset: reset asserted in WAIT -> all outputs 0 immediately, with no spurious tx_start or ack after release.
REQ-040 Stray tx_done_tick injected in IDLE -> no state change and no ack.
